// File: rtl/cla_pipelined_subtractor.sv
// cla_pipelined_subtractor: two-stage valid/ready pipelined a - b - borrow_in built on
// a parallel-prefix carry-lookahead adder, low half resolved in stage 1, high half in stage 2.
module cla_prefix #(
    parameter int N = 16
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         cin,
    output logic [N:0]   c
);
    logic [N-1:0] gg, pp;
    // Kogge-Stone prefix; carry-in folded into bit 0 so gg[i] is the carry out of bit i.
    always_comb begin
        gg    = g;
        pp    = p;
        gg[0] = g[0] | (p[0] & cin);
        for (int d = 1; d < N; d = d * 2)
            for (int i = N - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        c = {gg, cin};
    end
endmodule

module cla_pipelined_subtractor #(
    parameter int WIDTH = 32,
    parameter int SPLIT = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);
    localparam int HI = WIDTH - SPLIT;

    logic             s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
    logic [SPLIT-1:0] lo_q, lo_d;
    logic             cs_q;
    logic [HI-1:0]    a_hi_q, bi_hi_q, hi_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
    logic             s2_ready, in_fire, s2_fire;
    logic [SPLIT:0]   c_lo;
    logic [HI:0]      c_hi;

    assign s2_ready = !out_valid_q | out_ready;
    assign in_ready = !s1_valid_q | s2_ready;
    assign in_fire  = in_valid & in_ready;
    assign s2_fire  = s1_valid_q & s2_ready;

    // Subtraction as a + ~b + ~borrow_in.
    cla_prefix #(.N(SPLIT)) u_lo (
        .p  (a[SPLIT-1:0] ^ ~b[SPLIT-1:0]),
        .g  (a[SPLIT-1:0] & ~b[SPLIT-1:0]),
        .cin(~borrow_in),
        .c  (c_lo)
    );

    cla_prefix #(.N(HI)) u_hi (
        .p  (a_hi_q ^ bi_hi_q),
        .g  (a_hi_q & bi_hi_q),
        .cin(cs_q),
        .c  (c_hi)
    );

    always_comb begin
        lo_d        = a[SPLIT-1:0] ^ ~b[SPLIT-1:0] ^ c_lo[SPLIT-1:0];
        hi_d        = a_hi_q ^ bi_hi_q ^ c_hi[HI-1:0];
        diff_d      = {hi_d, lo_q};
        borrow_d    = ~c_hi[HI];
        ovf_d       = (a_hi_q[HI-1] ^ ~bi_hi_q[HI-1]) & (a_hi_q[HI-1] ^ hi_d[HI-1]);
        zero_d      = diff_d == '0;
        s1_valid_d  = in_fire ? 1'b1 : (s2_fire ? 1'b0 : s1_valid_q);
        out_valid_d = s2_fire ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            lo_q        <= '0;
            cs_q        <= 1'b0;
            a_hi_q      <= '0;
            bi_hi_q     <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (in_fire) begin
                lo_q    <= lo_d;
                cs_q    <= c_lo[SPLIT];
                a_hi_q  <= a[WIDTH-1:SPLIT];
                bi_hi_q <= ~b[WIDTH-1:SPLIT];
            end
            if (s2_fire) begin
                diff_q   <= diff_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;
endmodule

// File: tb/tb_cla_pipelined_subtractor.sv
// tb_cla_pipelined_subtractor: directed corner cases plus randomized valid/ready traffic
// checked against an arithmetic reference model and an in-order expectation queue.
module tb_cla_pipelined_subtractor;
    logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, borrow_in = 0;
    logic        out_valid, out_ready = 0, borrow_out, overflow, zero;
    logic [31:0] a = 0, b = 0, diff;
    int          n_chk = 0, n_fail = 0;
    logic [34:0] exp_q[$];

    cla_pipelined_subtractor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out),
        .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {zero, overflow, borrow_out, diff} from plain integer arithmetic.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [32:0] full;
        longint      s;
        full = {1'b0, x} - {1'b0, y} - {32'd0, bi};
        s    = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
        return {full[31:0] == 0, s > 64'sd2147483647 || s < -64'sd2147483648, full[32], full[31:0]};
    endfunction

    task automatic one(input string tag, input logic [31:0] x, input logic [31:0] y, input logic bi);
        logic [34:0] e;
        e = model(x, y, bi);
        @(negedge clk);
        a = x; b = y; borrow_in = bi; in_valid = 1; out_ready = 1;
        #1 check({tag, " in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 0; a = $urandom; b = $urandom;
        check({tag, " lat1"}, out_valid, 0);
        @(negedge clk);
        check({tag, " lat2"}, out_valid, 1);
        check({tag, " res"}, {zero, overflow, borrow_out, diff}, e);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] edges[4] = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        return ($urandom_range(3) == 0) ? edges[$urandom_range(3)] : $urandom;
    endfunction

    initial begin
        int          pushed, popped, cyc, inflight;
        logic        stalled;
        logic [34:0] held, got;
        #12;
        check("reset out_valid", out_valid, 0);
        check("reset diff", diff, 0);
        check("reset in_ready", in_ready, 1);
        rst_n = 1;

        one("t2", 32'd100, 32'd58, 0);
        check("t2 diff", diff, 42);
        one("t3a", 32'd0, 32'd1, 0);
        check("t3a diff", diff, 32'hFFFFFFFF);
        one("t3b", 32'd5, 32'd4, 1);
        check("t3b zero", zero, 1);
        one("t4a", 32'h80000000, 32'd1, 0);
        check("t4a ovf", overflow, 1);
        one("t4b", 32'h7FFFFFFF, 32'hFFFFFFFF, 0);
        check("t4b borrow", borrow_out, 1);
        one("t5", 32'h00010000, 32'd1, 0);
        check("t5 diff", diff, 32'h0000FFFF);

        // Fill with consumer stalled, then reset mid-stream.
        @(negedge clk);
        out_ready = 0; in_valid = 1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        @(negedge clk);
        #1 check("full in_ready", in_ready, 0);
        check("full out_valid", out_valid, 1);
        rst_n = 0;
        #1 check("async out_valid", out_valid, 0);
        check("async in_ready", in_ready, 1);
        check("async diff", diff, 0);
        @(negedge clk);
        in_valid = 0; out_ready = 1; rst_n = 1;
        repeat (3) @(negedge clk);
        check("no stale beat", out_valid, 0);

        // Full-rate streaming: one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1; out_ready = 1; a = pick(); b = pick(); borrow_in = 1'($urandom);
            #1 check("rate in_ready", in_ready, 1);
            if (i >= 2) check("rate out_valid", out_valid, 1);
        end
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);

        // Random traffic against the reference queue.
        pushed = 0; popped = 0; stalled = 0; held = '0; cyc = 0;
        while (popped < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid = (pushed < 1000) && ($urandom_range(3) != 0);
            out_ready = $urandom_range(2) != 0;
            a = pick(); b = pick(); borrow_in = 1'($urandom);
            #1;
            got = {zero, overflow, borrow_out, diff};
            if (stalled) begin
                check("stall valid", out_valid, 1);
                check("stall data", got, held);
            end
            inflight = pushed - popped;
            check("inflight<=2", inflight <= 2, 1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious beat", 1, 0);
                else check("stream result", got, exp_q.pop_front());
                popped++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, borrow_in));
                pushed++;
            end
            stalled = out_valid && !out_ready;
            held = got;
        end
        check("stream timeout", cyc < 20000, 1);
        check("stream drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
